// File: rtl/debounce_pkg.sv
// Shared types and helpers for the button debouncer array.
// The state encoding keeps bits [1:0] high only while the button is accepted.
package debounce_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMING  = 3'd1,
    PRESSED = 3'd3,
    LONG    = 3'd7,
    RELEASE = 3'd2
  } state_t;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: input sync flop, qualification/long/repeat/lockout FSM and
// registered one-cycle event pulses. All timing is counted in tick strobes.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS  = 2,
  parameter int LONG_TICKS    = 8,
  parameter int REPEAT_TICKS  = 4,
  parameter int RELEASE_TICKS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic button,
  output logic debounced,
  output logic press,
  output logic released,
  output logic long_press,
  output logic repeated
);

  localparam int MAX_TICKS = max(max(STABLE_TICKS, LONG_TICKS),
                                 max(REPEAT_TICKS, RELEASE_TICKS));
  localparam int CNT_W = $clog2(MAX_TICKS) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST    = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST  = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             button_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      button_d   <= 1'b0;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      repeated   <= 1'b0;
    end else begin
      button_d   <= button;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      repeated   <= 1'b0;
      // A low sample always beats a coincident tick in the active states.
      case (state)
        IDLE: begin
          if (tick && button_d) begin
            state <= ARMING;
            cnt   <= CNT_W'(1);
          end
        end
        ARMING: begin
          if (!button_d) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state <= PRESSED;
              cnt   <= '0;
              press <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!button_d) begin
            state    <= RELEASE;
            cnt      <= '0;
            released <= 1'b1;
          end else if (tick) begin
            if (cnt == LONG_LAST) begin
              state      <= LONG;
              cnt        <= '0;
              long_press <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LONG: begin
          if (!button_d) begin
            state    <= RELEASE;
            cnt      <= '0;
            released <= 1'b1;
          end else if (tick && (REPEAT_TICKS != 0)) begin
            if (cnt == REPEAT_LAST) begin
              cnt      <= '0;
              repeated <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RELEASE: begin
          if (tick) begin
            if (cnt == RELEASE_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign debounced = (state == PRESSED) || (state == LONG);

endmodule

// File: rtl/debouncer_array.sv
// Front-panel debouncer: CHANNELS independent debounce_channel instances
// sharing clock, reset and the slow tick strobe.
module debouncer_array
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_TICKS  = 2,
  parameter int LONG_TICKS    = 8,
  parameter int REPEAT_TICKS  = 4,
  parameter int RELEASE_TICKS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] repeated
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .RELEASE_TICKS(RELEASE_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .button    (button[i]),
      .debounced (debounced[i]),
      .press     (press[i]),
      .released  (released[i]),
      .long_press(long_press[i]),
      .repeated  (repeated[i])
    );
  end

endmodule
